mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS core. It sits directly downstream of the instruction decoder. It consumes the decoded mult/multu/div/divu/mthi/mtlo operations and rs/rt operands, holds the HI/LO architectural state, and reports busy status to the hazard/stall unit so that later HI/LO users wait for completion. mfhi/mflo read the `hi`/`lo` outputs directly.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (must be ≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (must be ≥1).

- `clk`: input, 1. Single clock; all state changes on its rising edge.
- `reset`: input, 1. Reset is asynchronous and active-high.
- `md_start`: input, 1. An MD operation is issued in EX this cycle.
- `md_op`: input, 3. Operation select: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 reserved.
- `md_a`: input, 32. rs value.
- `md_b`: input, 32. rt value.
- `md_cancel`: input, 1. Exception/interrupt taken this cycle. It suppresses the start issued in the same cycle.
- `busy`: output, 1. Registered; a mult/div is in flight.
- `md_in_use`: output, 1. Combinational: `busy` OR an accepted mult/div start this cycle. This is the stall unit's input.
- `hi`: output, 32. HI register.
- `lo`: output, 32. LO register.

## Operation
- A start is accepted when `md_start && !md_cancel && !busy && md_op <= 5`. Any other start is ignored with no state change.
- On an accepted mult/multu/div/divu:
  - The result is computed from `md_a`/`md_b` at the accept edge and latched into internal shadow registers `hi_pend`/`lo_pend`.
  - The counter loads `MULT_CYCLES` or `DIV_CYCLES`.
  - `busy` is set.
- **mult:** signed 32×32→64; `{hi,lo}` = product.
- **multu:** the same, unsigned.
- **div:** signed. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **divu:** unsigned quotient/remainder.
- **Divide by zero (div or divu):** the unit still goes busy for `DIV_CYCLES`, but HI/LO are left unchanged at commit.
- **mthi / mtlo:** `hi` (resp. `lo`) ← `md_a` at the accept edge. `busy` is not set; the other register is untouched.
- **State machine:** two states.
  - IDLE: `busy`=0. An accepted mult/div moves to RUN.
  - RUN: `busy`=1. The counter decrements each edge. On the edge where the counter goes 1→0, `hi`/`lo` ← `hi_pend`/`lo_pend` and the state returns to IDLE.
- **Cancel:**
  - `md_cancel` only blocks a start in the same cycle.
  - An operation already in RUN is not aborted and commits normally.
- **Start while busy** is ignored. The stall unit guarantees this never happens; the bench flags it as a protocol error.
- **Reset**, asynchronous and possible mid-operation: `hi`=0, `lo`=0, `busy`=0, counter=0, shadows=0, state IDLE. The pending result is discarded.

## Timing
- The accept edge is T0.
  - `busy` is 1 for cycles T0+1 … T0+N, where N = the op's cycle parameter.
  - `hi`/`lo` show the new values from the edge at T0+N onward.
  - `busy` is 0 in the cycle following T0+N.
  - A new start can be accepted in the first cycle after `busy` falls.
- `md_in_use` is high in the cycle of the accepted start and in every cycle `busy` is high. mfhi/mflo/mthi/mtlo/mult/div in ID stall on it.
- mthi/mtlo take effect one edge after acceptance.
- `hi`/`lo`/`busy` are registered outputs. `md_in_use` is the only combinational output.

## Test plan
- mult, a=0xFFFFFFFE (−2), b=3, default parameters.
  - `busy` is high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo hold their old values while `busy` is high.
- multu with the same operands.
  - After 5 cycles: hi=0x00000002, lo=0xFFFFFFFA.
- div cases, each checked after 10 cycles:
  - a=−7, b=2 gives lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
  - divu a=7, b=2 gives lo=3, hi=1.
  - div 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: preload with mthi 0x1234 then mtlo 0x5678, then issue div with b=0.
  - `busy` is high for 10 cycles.
  - Afterwards hi=0x1234, lo=0x5678.
- Start with `md_cancel`=1 (mult 3×4): no busy, hi/lo unchanged.
- Second start issued while busy: ignored, and the first result commits correctly.
- Assert `reset` at cycle 3 of a div.
  - Immediately (asynchronously) busy=0, hi=0, lo=0.
  - Nothing commits later.
  - A new mult accepted right after reset deasserts completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed at accept and committed when the busy window ends.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_cancel,
  output logic        busy,
  output logic        md_in_use,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [31:0] hi_pend;
  logic [31:0] lo_pend;

  logic accept;
  logic is_mul;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;

  assign busy    = (state == RUN);
  assign accept  = md_start && !md_cancel && !busy
                   && (md_op <= 3'd5);
  assign is_mul  = (md_op[2:1] == 2'b00);
  assign is_div  = (md_op[2:1] == 2'b01);
  assign is_mthi = (md_op == 3'd4);
  assign is_mtlo = (md_op == 3'd5);

  assign md_in_use = busy || (accept && !md_op[2]);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign prod_s = $signed({{32{md_a[31]}}, md_a})
                * $signed({{32{md_b[31]}}, md_b});
  assign prod_u = {32'b0, md_a} * {32'b0, md_b};

  // Signed divide works on magnitudes so MIN/-1 wraps cleanly
  logic        sgn;
  logic        neg_a;
  logic        neg_b;
  logic        dz;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign sgn   = !md_op[0];
  assign neg_a = sgn && md_a[31];
  assign neg_b = sgn && md_b[31];
  assign dz    = (md_b == 32'd0);
  assign dvd   = neg_a ? (~md_a + 32'd1) : md_a;
  assign dvs   = dz ? 32'd1
               : (neg_b ? (~md_b + 32'd1) : md_b);
  assign q_mag = dvd / dvs;
  assign r_mag = dvd % dvs;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    if (is_mul) begin
      res_hi = sgn ? prod_s[63:32] : prod_u[63:32];
      res_lo = sgn ? prod_s[31:0]  : prod_u[31:0];
    end else if (!dz) begin
      res_lo = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
      res_hi = neg_a ? (~r_mag + 32'd1) : r_mag;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && !md_op[2]) state_nxt = RUN;
      RUN:  if (cnt == 16'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      unique case (1'b1)
        is_mul: begin
          hi_pend <= res_hi;
          lo_pend <= res_lo;
          cnt     <= 16'(MULT_CYCLES);
        end
        is_div: begin
          hi_pend <= res_hi;
          lo_pend <= res_lo;
          cnt     <= 16'(DIV_CYCLES);
        end
        is_mthi: hi <= md_a;
        is_mtlo: lo <= md_a;
        default: ;
      endcase
    end else if (state == RUN) begin
      cnt <= cnt - 16'd1;
      if (cnt == 16'd1) begin
        hi <= hi_pend;
        lo <= lo_pend;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO and busy
// length are queued at issue and compared when busy drops.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_cancel;
  logic        busy;
  logic        md_in_use;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_a      (md_a),
    .md_b      (md_b),
    .md_cancel (md_cancel),
    .busy      (busy),
    .md_in_use (md_in_use),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one start for a single cycle; returns #1 after the edge
  task automatic issue(input logic [2:0]  op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic        cancel);
    @(negedge clk);
    md_start  = 1'b1;
    md_op     = op;
    md_a      = a;
    md_b      = b;
    md_cancel = cancel;
    #1;
    check("in_use_start", 64'(md_in_use),
          64'(!cancel && op <= 3'd3));
    @(posedge clk);
    #1;
    md_start  = 1'b0;
    md_cancel = 1'b0;
  endtask

  task automatic run_op(input logic [2:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input int          n,
                        input bit          inject);
    logic [31:0] ohi;
    logic [31:0] olo;
    int          cnt;
    exp_t        e;
    ohi = hi;
    olo = lo;
    cnt = 0;
    sb.push_back('{ehi, elo, n});
    issue(op, a, b, 1'b0);
    while (busy && cnt < 100) begin
      cnt++;
      check("hold_hilo", {hi, lo}, {ohi, olo});
      check("in_use_busy", 64'(md_in_use), 64'(1));
      if (inject && cnt == 2) begin
        $display("note: start driven while busy (protocol error)");
        md_start = 1'b1;
        md_op    = 3'd3;
        md_a     = 32'd100;
        md_b     = 32'd7;
      end
      @(posedge clk);
      #1;
      md_start = 1'b0;
    end
    e = sb.pop_front();
    check("busy_cycles", 64'(cnt), 64'(e.cycles));
    check("hi", 64'(hi), 64'(e.hi));
    check("lo", 64'(lo), 64'(e.lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] p;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    md_start  = 1'b0;
    md_op     = 3'd0;
    md_a      = '0;
    md_b      = '0;
    md_cancel = 1'b0;
    #2 reset  = 1'b1;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_hilo", {hi, lo}, 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_in_use", 64'(md_in_use), 64'(0));

    run_op(3'd0, 32'hFFFFFFFE, 32'd3,
           32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b0);
    run_op(3'd1, 32'hFFFFFFFE, 32'd3,
           32'h00000002, 32'hFFFFFFFA, 5, 1'b0);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
    run_op(3'd3, 32'd7, 32'd2,
           32'd1, 32'd3, 10, 1'b0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF,
           32'd0, 32'h80000000, 10, 1'b0);

    issue(3'd4, 32'h1234, 32'd0, 1'b0);
    check("mthi_hi", 64'(hi), 64'(32'h1234));
    check("mthi_busy", 64'(busy), 64'(0));
    issue(3'd5, 32'h5678, 32'd0, 1'b0);
    check("mtlo_hilo", {hi, lo}, {32'h1234, 32'h5678});
    run_op(3'd2, 32'd99, 32'd0,
           32'h1234, 32'h5678, 10, 1'b0);

    issue(3'd0, 32'd3, 32'd4, 1'b1);
    check("cancel_busy", 64'(busy), 64'(0));
    repeat (6) @(posedge clk);
    #1;
    check("cancel_hilo", {hi, lo}, {32'h1234, 32'h5678});

    issue(3'd6, 32'd3, 32'd4, 1'b0);
    check("reserved_busy", 64'(busy), 64'(0));

    run_op(3'd0, 32'hFFFFFFFE, 32'd3,
           32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b1);

    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_reset_busy", 64'(busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("async_busy", 64'(busy), 64'(0));
    check("async_hilo", {hi, lo}, 64'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("post_reset_busy", 64'(busy), 64'(0));
    check("post_reset_hilo", {hi, lo}, 64'(0));
    run_op(3'd0, 32'd5, 32'd7, 32'd0, 32'd35, 5, 1'b0);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      p  = longint'($signed(ra)) * longint'($signed(rb));
      run_op(3'd0, ra, rb, p[63:32], p[31:0], 5, 1'b0);
      p  = {32'b0, ra} * {32'b0, rb};
      run_op(3'd1, ra, rb, p[63:32], p[31:0], 5, 1'b0);
      rb = $urandom_range(1, 1000);
      run_op(3'd3, ra, rb, ra % rb, ra / rb, 10, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
